instruction_fetch: RTL
======================

# instruction_fetch

Upstream stage of the sequential RISC-V core: holds the 64-bit program counter, fetches 32-bit instructions from instruction memory over a request/response handshake, and presents each instruction with its PC to the instruction decoder via a valid/ready handshake. Branch/jump resolution from downstream redirects the PC and kills any younger in-flight or pending instruction. One outstanding memory request at most.

## Interface
- RESET_PC, 64'h0, PC value loaded on reset
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- imem_req  out  1  fetch request valid
- imem_addr  out  64  fetch address, equals internal pc
- imem_ready  in  1  memory accepts request this cycle (imem_req & imem_ready)
- imem_rvalid  in  1  read data valid for the accepted request
- imem_rdata  in  32  instruction word
- instr_valid  out  1  instruction available to decode
- instr  out  32  instruction word
- instr_pc  out  64  PC of instr
- instr_ready  in  1  decode consumes instr (instr_valid & instr_ready)
- redirect_valid  in  1  branch/jump taken, pulse
- redirect_pc  in  64  redirect target
- misalign_err  out  1  one-cycle pulse: redirect_pc[1:0] != 0

## Operation
- State machine: IDLE, REQ, WAIT, HOLD. Internal regs: pc, req_pc, drop, instr, instr_pc.
- IDLE: entered only by reset; unconditionally → REQ next cycle.
- REQ: imem_req=1, imem_addr=pc. On imem_ready: req_pc←pc, → WAIT.
- WAIT: on imem_rvalid with drop=0: instr←imem_rdata, instr_pc←req_pc, pc←req_pc+4, → HOLD. With drop=1: drop←0, → REQ (response discarded).
- HOLD: instr_valid = 1 & ~redirect_valid (combinational gate). On instr_valid & instr_ready: → REQ.
- Redirect (redirect_valid=1), target T = {redirect_pc[63:2], 2'b00}; pc←T in every state:
  - IDLE: → REQ.
  - REQ, imem_ready=0: stay REQ; address changes to T next cycle.
  - REQ, imem_ready=1: old request accepted, drop←1, → WAIT.
  - WAIT, no rvalid: drop←1, stay WAIT.
  - WAIT, rvalid same cycle: response discarded, drop←0, → REQ.
  - HOLD: held instruction discarded, never transferred, → REQ.
- misalign_err=1 in the cycle after any redirect with redirect_pc[1:0]!=0; redirect still taken with low bits cleared.
- PC arithmetic: unsigned 64-bit, wraps modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC + 4 = 0).
- imem_rvalid outside WAIT ignored.

## Timing
- Reset values: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=RESET_PC, misalign_err=0, drop=0.
- Reset mid-operation: immediate return to reset values; outstanding request abandoned, its late rvalid ignored.
- Zero-wait memory (imem_ready=1, rvalid one cycle after acceptance), decode always ready: REQ at t, WAIT t+1, instr_valid t+2, next REQ t+3 → one instruction per 3 cycles.
- First imem_req after reset deassertion: second rising edge.
- instr, instr_pc stable while instr_valid=1 and not consumed.
- Redirect to first imem_req with target: 1 cycle from REQ/HOLD/IDLE; from WAIT, 1 cycle after stale response returns.
- imem_req never high in WAIT/HOLD; at most one request outstanding.

## Test plan
- Reset release, RESET_PC=0x1000, zero-wait memory returning 0x00000013 → imem_addr 0x1000, 0x1004, 0x1008 in order; instr_pc matches; instr_valid every third cycle.
- Decode stalls (instr_ready=0 for 5 cycles) in HOLD → instr/instr_pc unchanged, imem_req stays 0, transfer on ready.
- Redirect to 0x2000 while in WAIT with rvalid delayed 3 cycles → stale data never presented; next imem_addr=0x2000, next instr_pc=0x2000.
- Redirect 0x3000 concurrent with imem_ready in REQ → old request completes and is dropped; next fetch 0x3000.
- Redirect in HOLD with instr_ready=1 same cycle → instr_valid=0 that cycle, no transfer; next fetch target. Redirect 0x4002 → misalign_err pulse, fetch 0x4000.
- PC wrap: RESET_PC=0xFFFF_FFFF_FFFF_FFFC → second fetch address 0x0. Reset asserted during WAIT → outputs at reset values immediately; late rvalid ignored.

Source files
------------

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues one instruction-memory request at a time
// and hands each fetched word (with its PC) to decode over valid/ready.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   imem_req/addr       fetch request and its address (always the current pc)
//   imem_ready          memory accepts the request this cycle
//   imem_rvalid/rdata   response for the accepted request
//   instr_valid/instr   fetched word offered to decode
//   instr_pc            PC of the offered word
//   instr_ready         decode takes the offered word
//   redirect_valid/pc   taken branch/jump; kills younger fetches
//   misalign_err        one-cycle flag after a redirect with pc[1:0] != 0
module instruction_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [63:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        misalign_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  logic [1:0]  state;
  logic [1:0]  state_n;
  logic [63:0] pc;
  logic [63:0] pc_n;
  logic [63:0] req_pc;
  logic [63:0] req_pc_n;
  logic        drop;
  logic        drop_n;
  logic [31:0] instr_n;
  logic [63:0] instr_pc_n;
  logic [63:0] target;

  assign target      = {redirect_pc[63:2], 2'b00};
  assign imem_req    = (state == REQ);
  assign imem_addr   = pc;
  // A redirect in HOLD kills the held word in the same cycle.
  assign instr_valid = (state == HOLD) && !redirect_valid;

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    req_pc_n   = req_pc;
    drop_n     = drop;
    instr_n    = instr;
    instr_pc_n = instr_pc;
    unique case (state)
      IDLE: state_n = REQ;
      REQ: begin
        if (imem_ready) begin
          req_pc_n = pc;
          state_n  = WAIT;
          // Request already left for the old path; swallow its reply.
          if (redirect_valid) drop_n = 1'b1;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          drop_n = 1'b0;
          if (drop || redirect_valid) begin
            state_n = REQ;
          end else begin
            instr_n    = imem_rdata;
            instr_pc_n = req_pc;
            pc_n       = req_pc + 64'd4;
            state_n    = HOLD;
          end
        end else if (redirect_valid) begin
          drop_n = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_valid || instr_ready) state_n = REQ;
      end
      default: state_n = IDLE;
    endcase
    if (redirect_valid) pc_n = target;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      req_pc       <= RESET_PC;
      drop         <= 1'b0;
      instr        <= 32'h0;
      instr_pc     <= RESET_PC;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      req_pc       <= req_pc_n;
      drop         <= drop_n;
      instr        <= instr_n;
      instr_pc     <= instr_pc_n;
      misalign_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);
    end
  end

endmodule
